// File: rtl/vpu_line_scanout.sv
// vpu_line_scanout: ping-pong scanline buffer streaming composed lines as valid/ready RGB (optional VPU_SCANOUT_TESTPATTERN_EN colour bars)
module vpu_line_scanout #(
    parameter int H_ACTIVE = 320,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int COLOR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [X_W-1:0]     in_x,
    input  logic [Y_W-1:0]     in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_line_end,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [23:0]        out_rgb,
    output logic [Y_W-1:0]     out_y,
    output logic               out_sol,
    output logic               out_eol,
    output logic               out_sof,
    output logic               overrun,
    input  logic               clr_overrun,
`ifdef VPU_SCANOUT_TESTPATTERN_EN
    input  logic               test_pattern,
`endif
    output logic               busy
);
    localparam int E_W = 24 + Y_W + 2;
    localparam logic [X_W-1:0] LAST = X_W'(H_ACTIVE - 1);
    localparam logic [X_W:0] HA = (X_W + 1)'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t         state, state_n;
    logic [23:0]    mem [2*H_ACTIVE];
    logic [1:0]     full;
    logic           wbank, rbank;
    logic [Y_W-1:0] line_y [2];
    logic [X_W-1:0] rx, rx_n;
    logic [1:0]     cnt, li;
    logic [E_W-1:0] slot [2];
    logic [E_W-1:0] push_e;
    logic [23:0]    rd_rgb;
    logic [X_W:0]   wa, ra;
    logic           issue, pop, rel, line_ok, unused_alpha;

    assign unused_alpha = ^in_color[COLOR_W-1:24];
    assign wa = {1'b0, in_x} + (wbank ? HA : '0);
    assign ra = {1'b0, rx} + (rbank ? HA : '0);
    assign out_valid = cnt != 2'd0;
    assign pop = out_valid && out_ready;
    assign {out_rgb, out_y, out_sol, out_eol} = slot[0];
    assign out_sof = out_sol && out_y == '0;
    assign busy = |full || state != IDLE;
    // a release of the other bank in the same cycle frees it for this swap
    assign line_ok = !full[~wbank] || (rel && rbank == ~wbank);
    // slot that receives a newly read pixel, after any pop has shifted the queue
    assign li = cnt - {1'b0, pop};
    assign push_e = {rd_rgb, line_y[rbank], rx == '0, rx == LAST};

`ifdef VPU_SCANOUT_TESTPATTERN_EN
    localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                         24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
    logic       tp_q;
    logic [2:0] bar;
    assign bar = 3'(rx / X_W'(H_ACTIVE / 8));
    assign rd_rgb = tp_q ? BARS[bar] : mem[ra];
    // test-pattern selection is frozen for the whole line at line start
    always_ff @(posedge clk or posedge rst)
        if (rst) tp_q <= 1'b0;
        else if (state == IDLE && full[rbank]) tp_q <= test_pattern;
`else
    assign rd_rgb = mem[ra];
`endif

    // compose-side writes; out-of-range x is dropped
    always_ff @(posedge clk)
        if (in_valid && in_x < X_W'(H_ACTIVE)) mem[wa] <= in_color[23:0];

    // reader next-state: read pixels while the skid has room, then wait for eol
    always_comb begin
        state_n = state;
        rx_n = rx;
        issue = 1'b0;
        rel = 1'b0;
        case (state)
            IDLE: if (full[rbank]) begin
                state_n = READ;
                rx_n = '0;
            end
            READ: begin
                issue = cnt != 2'd2 || pop;
                if (issue) begin
                    rx_n = rx == LAST ? rx : rx + 1'b1;
                    state_n = rx == LAST ? DRAIN : READ;
                end
            end
            DRAIN: begin
                rel = pop && out_eol;
                if (rel) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // reader state register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            rx <= '0;
        end else begin
            state <= state_n;
            rx <= rx_n;
        end

    // bank ownership, line numbers and sticky overrun
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            full <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            line_y[0] <= '0;
            line_y[1] <= '0;
            overrun <= 1'b0;
        end else begin
            full <= (full & ~(rel ? 2'b1 << rbank : 2'b0)) | ((in_line_end && line_ok) ? 2'b1 << wbank : 2'b0);
            if (rel) rbank <= ~rbank;
            if (in_line_end && line_ok) begin
                line_y[wbank] <= in_y;
                wbank <= ~wbank;
            end
            if (in_line_end && !line_ok) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end

    // two-entry output skid queue, head in slot[0]
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            cnt <= cnt + {1'b0, issue} - {1'b0, pop};
            if (pop) slot[0] <= slot[1];
            if (issue) slot[li[0]] <= push_e;
        end
endmodule
